scancode_decoder: RTL and testbench
===================================

SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 Parameter TIMEOUT, default 1000000, is the number of clk cycles a pending prefix waits for its next byte before it is discarded; legal range is 2..2^20-1.
REQ-002 clk  input  1  single clock; all logic updates on the rising edge.
REQ-003 i_sclr  input  1  synchronous, active-high reset.
REQ-004 i_byte  input  8  received PS/2 byte, sampled only when i_byte_valid=1.
REQ-005 i_byte_valid  input  1  single-cycle strobe, one per received byte.
REQ-006 o_scancode  output  8  scancode of the last emitted make event, held between events.
REQ-007 o_extended  output  1  last emitted make event was E0-prefixed, held with o_scancode.
REQ-008 o_valid  output  1  single-cycle pulse per emitted make event.
REQ-009 o_shift  output  1  left shift (0x12) or right shift (0x59) is currently held.
REQ-010 o_capslock  output  1  caps-lock latch state.

Function
REQ-011 The FSM has states IDLE, EXT, BRK and EXT_BRK, and transitions only on cycles with i_byte_valid=1 or on timeout.
REQ-012 In IDLE: 0xF0 goes to BRK, 0xE0 goes to EXT, 0xE1 is discarded and the FSM stays in IDLE, and any other byte is a plain make event that stays in IDLE.
REQ-013 In EXT: 0xF0 goes to EXT_BRK, and any other byte is an extended make event that returns to IDLE.
REQ-014 In BRK, any byte is a plain break event; in EXT_BRK, any byte is an extended break event; both return to IDLE.
REQ-015 Make events drive o_valid=1, update o_scancode/o_extended and update the modifiers one cycle after the completing strobe; latency is 1 cycle.
REQ-016 Break events never assert o_valid and update only the modifier and filter state.
REQ-017 A plain make of 0x12 sets lshift, a plain break of 0x12 clears it, and 0x59 does the same for rshift; o_shift = lshift | rshift.
REQ-018 Extended 0x12/0x59 (print-screen fake shift) does not affect shift state and is not emitted.
REQ-019 A plain make of 0x58 toggles o_capslock only when caps_held=0, then sets caps_held; a plain break of 0x58 clears caps_held, so a held key toggles once.
REQ-020 Modifier make codes 0x12, 0x59 and 0x58 are still emitted with o_valid, because the downstream converter purges them itself.
REQ-021 A 20-bit timeout counter clears when the FSM enters or leaves IDLE and on every accepted byte, and counts while the FSM is not in IDLE.
REQ-022 When the count reaches TIMEOUT-1 with no strobe, the FSM returns to IDLE with no event and no modifier change.
REQ-023 If a strobe arrives in the same cycle as the timeout, the byte is processed normally and the timeout is ignored.
REQ-024 Back-to-back strobes on consecutive cycles are each processed, with no byte lost.
REQ-025 o_valid is never asserted for prefix bytes, breaks, discarded 0xE1 bytes or filtered makes.

Reset
REQ-026 While i_sclr=1, on each clk edge: FSM=IDLE, counter=0, o_scancode=0x00, o_extended=0, o_valid=0, lshift=rshift=0, o_capslock=0, caps_held=0, and filter state is cleared.
REQ-027 i_sclr overrides a simultaneous i_byte_valid; a prefix pending at reset is dropped.
REQ-028 The first strobe after reset deasserts is processed normally.

Configuration
REQ-029 With macro KB_TYPEMATIC_FILTER_EN defined, the block stores the last emitted make {extended, scancode} plus a held flag.
REQ-030 With KB_TYPEMATIC_FILTER_EN defined, a make equal to the stored key while held=1 is suppressed (no o_valid, no output change), a break of the stored key clears held, and a different make is emitted and becomes the stored key.
REQ-031 Without KB_TYPEMATIC_FILTER_EN, every make, including typematic repeats, is emitted, and no filter state exists.

Verification
REQ-032 Bytes 1C, F0, 1C -> one o_valid pulse with o_scancode=0x1C and o_extended=0, no pulse for F0 or the break, and FSM ends in IDLE.
REQ-033 Bytes 12, 1C, F0, 12 -> o_shift=1 from the 0x12 event through the break, and 0 one cycle after the final byte.
REQ-034 Bytes 58, 58, 58, F0, 58, 58 -> o_capslock toggles 0->1 on the first make, stays 1 through the repeats, and returns to 0 on the make after the break.
REQ-035 Bytes E0, 5A -> o_valid with o_scancode=0x5A and o_extended=1; bytes E0, 12 -> no pulse and o_shift stays 0.
REQ-036 Byte F0 followed by TIMEOUT idle cycles, then 1C -> 1C is emitted as a make; F0 followed by assertion of i_sclr mid-prefix -> all outputs return to 0.
REQ-037 Bytes 1C, 1C, 1C -> three o_valid pulses without KB_TYPEMATIC_FILTER_EN, and one pulse with it.

Source files
------------

// File: rtl/scancode_decoder.sv
// -----------------------------------------------------------------------------
// scancode_decoder
//
// Purpose:
//   Turns a stream of PS/2 set-2 bytes into make events. It handles the E0
//   (extended) and F0 (break) prefixes and drops E1 bytes. It also tracks the
//   shift and caps-lock modifiers. A prefix that gets no follow-up byte within
//   TIMEOUT clock cycles is dropped.
//
// Parameters:
//   TIMEOUT        clk cycles a pending prefix waits for its next byte
//                  (legal range 2 .. 2^20-1)
//
// Optional feature:
//   KB_TYPEMATIC_FILTER_EN  when defined, typematic repeats of the key that
//                           is currently held are suppressed
//
// Ports:
//   clk            single clock, rising edge
//   i_sclr         synchronous active-high clear
//   i_byte         received PS/2 byte, valid with i_byte_valid
//   i_byte_valid   one-cycle strobe per received byte
//   o_scancode     scancode of the last emitted make event (held)
//   o_extended     last emitted make event was E0-prefixed (held)
//   o_valid        one-cycle pulse per emitted make event
//   o_shift        left or right shift is currently held
//   o_capslock     caps-lock latch state
// -----------------------------------------------------------------------------
module scancode_decoder #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic [7:0] o_scancode,
  output logic       o_extended,
  output logic       o_valid,
  output logic       o_shift,
  output logic       o_capslock
);

  localparam logic [7:0]  BYTE_BRK    = 8'hF0;
  localparam logic [7:0]  BYTE_EXT    = 8'hE0;
  localparam logic [7:0]  BYTE_PAUSE  = 8'hE1;
  localparam logic [7:0]  KEY_LSHIFT  = 8'h12;
  localparam logic [7:0]  KEY_RSHIFT  = 8'h59;
  localparam logic [7:0]  KEY_CAPS    = 8'h58;
  localparam logic [19:0] CNT_LAST    = 20'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  scancode_q, scancode_d;
  logic        extended_q, extended_d;
  logic        valid_q, valid_d;
  logic        lshift_q, lshift_d;
  logic        rshift_q, rshift_d;
  logic        caps_q, caps_d;
  logic        caps_held_q, caps_held_d;

  // Decoded event for the byte in this cycle.
  logic make_evt;
  logic brk_evt;
  logic evt_ext;
  logic fake_shift;
  logic suppress;
  logic emit;

  // ---------------------------------------------------------------------------
  // Prefix FSM and timeout counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    make_evt = 1'b0;
    brk_evt  = 1'b0;
    evt_ext  = 1'b0;

    if (i_byte_valid) begin
      // A strobe always wins over a coincident timeout.
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (i_byte == BYTE_BRK) begin
            state_d = S_BRK;
          end else if (i_byte == BYTE_EXT) begin
            state_d = S_EXT;
          end else if (i_byte != BYTE_PAUSE) begin
            make_evt = 1'b1;
          end
        end
        S_EXT: begin
          if (i_byte == BYTE_BRK) begin
            state_d = S_EXT_BRK;
          end else begin
            make_evt = 1'b1;
            evt_ext  = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          brk_evt = 1'b1;
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          brk_evt = 1'b1;
          evt_ext = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  // The E0 12 / E0 59 pairs that print-screen sends are fake shifts; they
  // neither touch the modifiers nor produce an event.
  assign fake_shift = evt_ext && (i_byte == KEY_LSHIFT || i_byte == KEY_RSHIFT);

  // ---------------------------------------------------------------------------
  // Typematic filter
  // ---------------------------------------------------------------------------
`ifdef KB_TYPEMATIC_FILTER_EN
  logic [8:0] filt_key_q, filt_key_d;
  logic       filt_held_q, filt_held_d;

  always_comb begin
    filt_key_d  = filt_key_q;
    filt_held_d = filt_held_q;
    suppress    = make_evt && !fake_shift && filt_held_q &&
                  (filt_key_q == {evt_ext, i_byte});
    if (make_evt && !fake_shift && !suppress) begin
      filt_key_d  = {evt_ext, i_byte};
      filt_held_d = 1'b1;
    end else if (brk_evt && (filt_key_q == {evt_ext, i_byte})) begin
      filt_held_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      filt_key_q  <= '0;
      filt_held_q <= 1'b0;
    end else begin
      filt_key_q  <= filt_key_d;
      filt_held_q <= filt_held_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign emit = make_evt && !fake_shift && !suppress;

  // ---------------------------------------------------------------------------
  // Output and modifier next state
  // ---------------------------------------------------------------------------
  always_comb begin
    scancode_d  = scancode_q;
    extended_d  = extended_q;
    valid_d     = emit;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;

    if (emit) begin
      scancode_d = i_byte;
      extended_d = evt_ext;
    end

    // Modifiers react only to plain (non-E0) make and break codes.
    if (make_evt && !evt_ext) begin
      if (i_byte == KEY_LSHIFT) lshift_d = 1'b1;
      if (i_byte == KEY_RSHIFT) rshift_d = 1'b1;
      if (i_byte == KEY_CAPS) begin
        // Toggle only on the first make, so a held key toggles once.
        if (!caps_held_q) caps_d = !caps_q;
        caps_held_d = 1'b1;
      end
    end else if (brk_evt && !evt_ext) begin
      if (i_byte == KEY_LSHIFT) lshift_d    = 1'b0;
      if (i_byte == KEY_RSHIFT) rshift_d    = 1'b0;
      if (i_byte == KEY_CAPS)   caps_held_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_sclr) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      scancode_q  <= '0;
      extended_q  <= 1'b0;
      valid_q     <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scancode_q  <= scancode_d;
      extended_q  <= extended_d;
      valid_q     <= valid_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
    end
  end

  assign o_scancode = scancode_q;
  assign o_extended = extended_q;
  assign o_valid    = valid_q;
  assign o_shift    = lshift_q | rshift_q;
  assign o_capslock = caps_q;

endmodule

// File: tb/tb_scancode_decoder.sv
// -----------------------------------------------------------------------------
// tb_scancode_decoder
//
// Directed bench for scancode_decoder with a short TIMEOUT. Inputs change on
// the falling edge, so each byte is taken at the next rising edge and the
// registered outputs are sampled on the falling edge after that.
// -----------------------------------------------------------------------------
module tb_scancode_decoder;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       i_sclr;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic [7:0] o_scancode;
  logic       o_extended;
  logic       o_valid;
  logic       o_shift;
  logic       o_capslock;

  int n_total = 0;
  int n_bad   = 0;
  int pulses  = 0;

  scancode_decoder #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .i_sclr       (i_sclr),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_scancode   (o_scancode),
    .o_extended   (o_extended),
    .o_valid      (o_valid),
    .o_shift      (o_shift),
    .o_capslock   (o_capslock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns on the falling edge after the
  // rising edge that took it, where the outputs already reflect it.
  task automatic send(input logic [7:0] b);
    i_byte       = b;
    i_byte_valid = 1'b1;
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    i_sclr       = 1'b1;
    i_byte       = 8'h00;
    i_byte_valid = 1'b0;
    idle(3);
    check("rst_scancode", o_scancode, 8'h00);
    check("rst_extended", {7'd0, o_extended}, 8'h00);
    check("rst_valid",    {7'd0, o_valid},    8'h00);
    check("rst_shift",    {7'd0, o_shift},    8'h00);
    check("rst_caps",     {7'd0, o_capslock}, 8'h00);
    i_sclr = 1'b0;
    idle(1);

    // Make, then break of the same key.
    send(8'h1C);
    check("a_make_valid", {7'd0, o_valid}, 8'h01);
    check("a_make_code",  o_scancode,      8'h1C);
    check("a_make_ext",   {7'd0, o_extended}, 8'h00);
    send(8'hF0);
    check("a_f0_valid",   {7'd0, o_valid}, 8'h00);
    check("a_f0_hold",    o_scancode,      8'h1C);
    send(8'h1C);
    check("a_brk_valid",  {7'd0, o_valid}, 8'h00);
    send(8'h2B);
    check("a_idle_valid", {7'd0, o_valid}, 8'h01);
    check("a_idle_code",  o_scancode,      8'h2B);

    // Left shift held across another key.
    send(8'h12);
    check("b_12_valid", {7'd0, o_valid}, 8'h01);
    check("b_12_code",  o_scancode,      8'h12);
    check("b_12_shift", {7'd0, o_shift}, 8'h01);
    send(8'h1C);
    check("b_1c_shift", {7'd0, o_shift}, 8'h01);
    send(8'hF0);
    check("b_f0_shift", {7'd0, o_shift}, 8'h01);
    send(8'h12);
    check("b_brk_shift", {7'd0, o_shift}, 8'h00);
    check("b_brk_valid", {7'd0, o_valid}, 8'h00);

    // Caps lock toggles once per press.
    send(8'h58);
    check("c_1_caps",  {7'd0, o_capslock}, 8'h01);
    check("c_1_valid", {7'd0, o_valid},    8'h01);
    send(8'h58);
    check("c_2_caps",  {7'd0, o_capslock}, 8'h01);
    send(8'h58);
    check("c_3_caps",  {7'd0, o_capslock}, 8'h01);
    send(8'hF0);
    send(8'h58);
    check("c_brk_caps",  {7'd0, o_capslock}, 8'h01);
    check("c_brk_valid", {7'd0, o_valid},    8'h00);
    send(8'h58);
    check("c_4_caps",  {7'd0, o_capslock}, 8'h00);
    check("c_4_valid", {7'd0, o_valid},    8'h01);
    send(8'h58);
    check("c_5_caps",  {7'd0, o_capslock}, 8'h00);

    // Extended make and fake shift.
    send(8'hE0);
    check("d_e0_valid", {7'd0, o_valid}, 8'h00);
    send(8'h5A);
    check("d_5a_valid", {7'd0, o_valid},    8'h01);
    check("d_5a_code",  o_scancode,         8'h5A);
    check("d_5a_ext",   {7'd0, o_extended}, 8'h01);
    send(8'hE0);
    send(8'h12);
    check("d_fake_valid", {7'd0, o_valid}, 8'h00);
    check("d_fake_shift", {7'd0, o_shift}, 8'h00);
    check("d_fake_code",  o_scancode,      8'h5A);
    send(8'h59);
    check("d_rs_shift", {7'd0, o_shift}, 8'h01);
    send(8'hF0);
    send(8'h59);
    check("d_rs_rel",   {7'd0, o_shift}, 8'h00);
    send(8'h12);
    send(8'hE0);
    send(8'hF0);
    send(8'h12);
    check("d_fakebrk_shift", {7'd0, o_shift}, 8'h01);
    send(8'hF0);
    send(8'h12);
    check("d_ls_rel", {7'd0, o_shift}, 8'h00);

    // E1 is discarded and the FSM stays idle.
    send(8'hE1);
    check("e_e1_valid", {7'd0, o_valid}, 8'h00);
    send(8'h1C);
    check("e_1c_valid", {7'd0, o_valid},    8'h01);
    check("e_1c_code",  o_scancode,         8'h1C);
    check("e_1c_ext",   {7'd0, o_extended}, 8'h00);

    // Timeout: TO idle cycles drop the prefix, TO-1 do not.
    send(8'hF0);
    idle(TO);
    send(8'h33);
    check("t_full_valid", {7'd0, o_valid}, 8'h01);
    check("t_full_code",  o_scancode,      8'h33);
    send(8'hF0);
    idle(TO - 1);
    send(8'h33);
    check("t_short_valid", {7'd0, o_valid}, 8'h00);
    send(8'h33);
    check("t_after_valid", {7'd0, o_valid}, 8'h01);
    send(8'hE0);
    idle(TO);
    send(8'h12);
    check("t_ext_valid", {7'd0, o_valid},    8'h01);
    check("t_ext_ext",   {7'd0, o_extended}, 8'h00);
    check("t_ext_shift", {7'd0, o_shift},    8'h01);
    send(8'hF0);
    send(8'h12);
    check("t_ext_rel", {7'd0, o_shift}, 8'h00);

    // Clear with a prefix pending and a coincident strobe.
    send(8'hF0);
    send(8'h58);
    send(8'h58);
    check("r_pre_caps", {7'd0, o_capslock}, 8'h01);
    send(8'h12);
    check("r_pre_shift", {7'd0, o_shift}, 8'h01);
    send(8'hF0);
    i_sclr       = 1'b1;
    i_byte       = 8'h12;
    i_byte_valid = 1'b1;
    @(negedge clk);
    i_sclr       = 1'b0;
    i_byte_valid = 1'b0;
    check("r_code",  o_scancode,         8'h00);
    check("r_ext",   {7'd0, o_extended}, 8'h00);
    check("r_valid", {7'd0, o_valid},    8'h00);
    check("r_shift", {7'd0, o_shift},    8'h00);
    check("r_caps",  {7'd0, o_capslock}, 8'h00);
    send(8'h1C);
    check("r_first_valid", {7'd0, o_valid}, 8'h01);
    check("r_first_code",  o_scancode,      8'h1C);

    // Typematic repeats.
    send(8'hF0);
    send(8'h1C);
    pulses = 0;
    repeat (3) begin
      send(8'h1C);
      if (o_valid) pulses++;
    end
`ifdef KB_TYPEMATIC_FILTER_EN
    check("rep_pulses", 8'(pulses), 8'd1);
`else
    check("rep_pulses", 8'(pulses), 8'd3);
`endif
    idle(1);
    check("rep_end_valid", {7'd0, o_valid}, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
